scan_history_disp: RTL and testbench
====================================

SCAN_HISTORY_DISP -- requirements
Module: scan_history_disp

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 3, number of byte slots shown; each slot uses two hex digits; legal range 1..8.
REQ-002 SHALL have parameter FILTER_BREAK, default 1; 1 drops PS/2 break sequences, 0 shows every byte.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 drives segment outputs active-low.
REQ-004 SHALL provide port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL provide port valid, input, 1, one-cycle pulse qualifying data.
REQ-007 SHALL provide port data, input, 8, received scancode byte.
REQ-008 SHALL provide port clear, input, 1, blanks all slots when high for one cycle.
REQ-009 SHALL provide port freeze, input, 1, holds the display while high.
REQ-010 SHALL provide port seg, output, NUM_SLOTS*16, digit k at bits [8k+7:8k]; digit 2s is slot s low nibble, digit 2s+1 is slot s high nibble.
REQ-011 SHALL provide port key_count, output, 8, number of accepted make codes, wrapping.

Function
REQ-012 SHALL hold a history of NUM_SLOTS bytes, each with an occupied flag; slot 0 is newest.
REQ-013 SHALL, on push, move slot s to slot s+1 for all s, discard the oldest slot, and load slot 0 with data marked occupied.
REQ-014 SHALL encode each digit as segment bit 7=a down to bit 1=g, bit 0=dp; dp is always off.
REQ-015 SHALL decode nibbles 0-F as standard hex glyphs (b and d lower-case), then invert when ACTIVE_LOW=1.
REQ-016 SHALL drive unoccupied slots blank: all segments off, which is 8'hFF when ACTIVE_LOW=1 and 8'h00 otherwise.
REQ-017 SHALL register seg, so that a push accepted in cycle N is visible in cycle N+1.
REQ-018 SHALL, when FILTER_BREAK=1, implement the states IDLE, EXT and BREAK.
- IDLE: byte E0 goes to EXT and is not pushed; byte F0 goes to BREAK and is not pushed; any other byte is pushed as a make code, and the state stays IDLE.
- EXT: byte F0 goes to BREAK and is not pushed; any other byte is pushed as a make code and returns to IDLE.
- BREAK: the next byte is dropped and returns to IDLE.
REQ-019 SHALL, when FILTER_BREAK=0, push every valid byte and increment key_count on every push.
REQ-020 SHALL increment key_count by 1 on each make-code push, wrapping FF to 00.
REQ-021 SHALL, while freeze=1, suppress pushes and key_count increments, while the FSM still consumes bytes and changes state.
REQ-022 SHALL, on clear, reset all occupied flags to 0 and the FSM to IDLE, with key_count unchanged.
REQ-023 SHALL give clear priority over a simultaneous valid; that byte is dropped.
REQ-024 SHALL ignore data when valid=0.

Reset
REQ-025 SHALL, on rst, clear all slots to unoccupied, so seg shows all digits blank from the next cycle.
REQ-026 SHALL, on rst, set the FSM to IDLE and key_count to 0.
REQ-027 SHALL abandon any partial E0/F0 sequence when rst is asserted mid-sequence.
REQ-028 SHALL give rst priority over clear, valid and freeze.

Structure
REQ-029 SHALL place shared constants in package scan_disp_pkg:
- FSM state typedef;
- SEG_BLANK;
- prefix bytes E0 and F0;
- the hex glyph table.
REQ-030 SHALL use one sub-module, hex7seg: combinational 4-bit to 8-bit decoder, active-high; inversion and blanking stay in the parent.
REQ-031 SHALL generate history storage and hex7seg instances per slot from NUM_SLOTS.

Verification
REQ-032 SHALL check reset: assert rst, then observe seg all 8'hFF per digit and key_count=0.
REQ-033 SHALL check make codes: push 1C, then 32 (NUM_SLOTS=3, FILTER_BREAK=1).
- Required: slot0 shows "32" (digit1=3, digit0=2), slot1 shows "1C", slot2 blank, key_count=2.
REQ-034 SHALL check break filtering: push 1C, F0, 1C.
- Required: only one "1C" displayed, key_count=1, FSM back in IDLE.
REQ-035 SHALL check extended codes: push E0, 75, E0, F0, 75.
- Required: slot0 shows "75" once, key_count=1.
REQ-036 SHALL check overflow: push 4 bytes 11, 22, 33, 44 with NUM_SLOTS=3.
- Required: slots show 44, 33, 22; 11 discarded.
REQ-037 SHALL check clear and freeze.
- clear with simultaneous valid: all slots blank, byte dropped.
- freeze with 2A pushed: display and key_count unchanged.

Source files
------------

// File: rtl/scan_disp_pkg.sv
// Shared constants for the scancode history display: FSM states, prefix bytes and hex glyphs.
package scan_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXT   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned NIBBLE_W = 4;

  // Active-high encoding of a dark digit; the parent inverts for active-low panels.
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  localparam logic [BYTE_W-1:0] PFX_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PFX_BREAK = 8'hF0;

  // Bit 7 = a ... bit 1 = g, bit 0 = dp (always off); entry 15 first.
  localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/scan_history_disp_hex7seg.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module hex7seg
  import scan_disp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    segs_c
);

  assign segs_c = HEX_GLYPH[nibble];

endmodule

// File: rtl/scan_history_disp.sv
// PS/2 scancode history shown as hex digits, newest byte in slot 0, with break-code filtering.
module scan_history_disp
  import scan_disp_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 3,
  parameter bit          FILTER_BREAK = 1'b1,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [BYTE_W-1:0]          data,
  input  logic                       clear,
  input  logic                       freeze,
  output logic [NUM_SLOTS*16-1:0]    seg,
  output logic [BYTE_W-1:0]          key_count
);

  localparam int unsigned DIGITS = NUM_SLOTS * 2;
  localparam logic [SEG_W-1:0] BLANK_OUT = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  state_t state, state_nxt;
  logic   push_c;

  logic [NUM_SLOTS-1:0][BYTE_W-1:0] slot_q, slot_d;
  logic [NUM_SLOTS-1:0]             occ_q, occ_d;
  logic [NUM_SLOTS*16-1:0]          seg_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: prefixes advance the FSM even while frozen
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (valid && FILTER_BREAK) begin
      unique case (state)
        ST_IDLE: begin
          if (data == PFX_EXT)        state_nxt = ST_EXT;
          else if (data == PFX_BREAK) state_nxt = ST_BREAK;
        end
        ST_EXT:   state_nxt = (data == PFX_BREAK) ? ST_BREAK : ST_IDLE;
        ST_BREAK: state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode: which bytes land in the history
  always_comb begin
    push_c = 1'b0;
    if (valid && !clear && !freeze) begin
      if (!FILTER_BREAK) begin
        push_c = 1'b1;
      end else begin
        unique case (state)
          ST_IDLE:  push_c = (data != PFX_EXT) && (data != PFX_BREAK);
          ST_EXT:   push_c = (data != PFX_BREAK);
          ST_BREAK: push_c = 1'b0;
          default:  push_c = 1'b0;
        endcase
      end
    end
  end

  // Shift register next values and per-slot digit rendering
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [SEG_W-1:0] glyph_lo_c, glyph_hi_c;

    if (s == 0) begin : g_head
      assign slot_d[s] = push_c ? data : slot_q[s];
      assign occ_d[s]  = clear ? 1'b0 : (push_c ? 1'b1 : occ_q[s]);
    end else begin : g_tail
      assign slot_d[s] = push_c ? slot_q[s-1] : slot_q[s];
      assign occ_d[s]  = clear ? 1'b0 : (push_c ? occ_q[s-1] : occ_q[s]);
    end

    hex7seg u_lo (.nibble(slot_d[s][3:0]), .segs_c(glyph_lo_c));
    hex7seg u_hi (.nibble(slot_d[s][7:4]), .segs_c(glyph_hi_c));

    assign seg_d[16*s +: 8]     = occ_d[s] ? (ACTIVE_LOW ? ~glyph_lo_c : glyph_lo_c) : BLANK_OUT;
    assign seg_d[16*s + 8 +: 8] = occ_d[s] ? (ACTIVE_LOW ? ~glyph_hi_c : glyph_hi_c) : BLANK_OUT;
  end

  // History, display and counter registers; seg is fed from next-state so a push shows one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      occ_q     <= '0;
      seg       <= {DIGITS{BLANK_OUT}};
      key_count <= '0;
    end else begin
      slot_q <= slot_d;
      occ_q  <= occ_d;
      seg    <= seg_d;
      if (push_c) key_count <= key_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_scan_history_disp.sv
// Directed bench for scan_history_disp with default parameters (3 slots, break filter, active-low).
module tb_scan_history_disp;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic        clear;
  logic        freeze;
  logic [47:0] seg;
  logic [7:0]  key_count;

  int vectors;
  int miscompares;

  // Active-low two-digit slot images {high digit, low digit}
  localparam logic [15:0] S_BLANK = 16'hFFFF;
  localparam logic [15:0] S_32    = 16'h0D25;
  localparam logic [15:0] S_1C    = 16'h9F63;
  localparam logic [15:0] S_75    = 16'h1F49;
  localparam logic [15:0] S_44    = 16'h9999;
  localparam logic [15:0] S_33    = 16'h0D0D;
  localparam logic [15:0] S_22    = 16'h2525;
  localparam logic [15:0] S_11    = 16'h9F9F;
  localparam logic [15:0] S_2A    = 16'h2511;
  localparam logic [15:0] S_01    = 16'h039F;

  scan_history_disp dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .clear(clear),
    .freeze(freeze), .seg(seg), .key_count(key_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    @(negedge clk);
    valid = 1'b0;
    data  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b1; data = 8'h1C;
    do_reset();
    valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (seg !== {3{S_BLANK}}) begin
      miscompares++;
      $display("FAIL reset_seg: got %h want %h", seg, {3{S_BLANK}});
    end
    vectors++;
    if (key_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d want 0", key_count);
    end
  endtask

  task automatic test_make();
    do_reset();
    send(8'h1C);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_1C}) begin
      miscompares++;
      $display("FAIL make_first_latency: got %h want %h", seg, {S_BLANK, S_BLANK, S_1C});
    end
    send(8'h32);
    vectors++;
    if (seg !== {S_BLANK, S_1C, S_32}) begin
      miscompares++;
      $display("FAIL make_seg: got %h want %h", seg, {S_BLANK, S_1C, S_32});
    end
    vectors++;
    if (key_count !== 8'd2) begin
      miscompares++;
      $display("FAIL make_count: got %0d want 2", key_count);
    end
  endtask

  task automatic test_break();
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_1C}) begin
      miscompares++;
      $display("FAIL break_seg: got %h want %h", seg, {S_BLANK, S_BLANK, S_1C});
    end
    vectors++;
    if (key_count !== 8'd1) begin
      miscompares++;
      $display("FAIL break_count: got %0d want 1", key_count);
    end
    // Back in IDLE: next ordinary byte is a make code
    send(8'h2A);
    vectors++;
    if (seg !== {S_BLANK, S_1C, S_2A} || key_count !== 8'd2) begin
      miscompares++;
      $display("FAIL break_idle: got %h/%0d want %h/2", seg, key_count, {S_BLANK, S_1C, S_2A});
    end
  endtask

  task automatic test_ext();
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_75}) begin
      miscompares++;
      $display("FAIL ext_seg: got %h want %h", seg, {S_BLANK, S_BLANK, S_75});
    end
    vectors++;
    if (key_count !== 8'd1) begin
      miscompares++;
      $display("FAIL ext_count: got %0d want 1", key_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    vectors++;
    if (seg !== {S_22, S_33, S_44}) begin
      miscompares++;
      $display("FAIL overflow_seg: got %h want %h", seg, {S_22, S_33, S_44});
    end
    vectors++;
    if (key_count !== 8'd4) begin
      miscompares++;
      $display("FAIL overflow_count: got %0d want 4", key_count);
    end
  endtask

  task automatic test_clear();
    // Continues from overflow state: three slots filled, count 4
    @(negedge clk);
    clear = 1'b1; valid = 1'b1; data = 8'h55;
    @(negedge clk);
    clear = 1'b0; valid = 1'b0;
    vectors++;
    if (seg !== {3{S_BLANK}}) begin
      miscompares++;
      $display("FAIL clear_seg: got %h want %h", seg, {3{S_BLANK}});
    end
    vectors++;
    if (key_count !== 8'd4) begin
      miscompares++;
      $display("FAIL clear_count: got %0d want 4", key_count);
    end
    // Clear also returns the FSM to IDLE
    send(8'hF0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    send(8'h1C);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_1C} || key_count !== 8'd5) begin
      miscompares++;
      $display("FAIL clear_fsm: got %h/%0d want %h/5", seg, key_count, {S_BLANK, S_BLANK, S_1C});
    end
  endtask

  task automatic test_freeze();
    // Continues from clear state: slot0 = 1C, count 5
    freeze = 1'b1;
    send(8'h2A);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_1C} || key_count !== 8'd5) begin
      miscompares++;
      $display("FAIL freeze_hold: got %h/%0d want %h/5", seg, key_count, {S_BLANK, S_BLANK, S_1C});
    end
    // F0 consumed while frozen still arms BREAK, so the following byte is dropped
    send(8'hF0);
    freeze = 1'b0;
    send(8'h11);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_1C} || key_count !== 8'd5) begin
      miscompares++;
      $display("FAIL freeze_fsm: got %h/%0d want %h/5", seg, key_count, {S_BLANK, S_BLANK, S_1C});
    end
    send(8'h32);
    vectors++;
    if (seg !== {S_BLANK, S_1C, S_32} || key_count !== 8'd6) begin
      miscompares++;
      $display("FAIL freeze_release: got %h/%0d want %h/6", seg, key_count, {S_BLANK, S_1C, S_32});
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h11);
    vectors++;
    if (seg !== {S_BLANK, S_BLANK, S_11} || key_count !== 8'd1) begin
      miscompares++;
      $display("FAIL rst_mid_seq: got %h/%0d want %h/1", seg, key_count, {S_BLANK, S_BLANK, S_11});
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send(8'h01);
    vectors++;
    if (key_count !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_ff: got %h want ff", key_count);
    end
    send(8'h01);
    vectors++;
    if (key_count !== 8'h00 || seg !== {3{S_01}}) begin
      miscompares++;
      $display("FAIL wrap_00: got %h/%h want 00/%h", key_count, seg, {3{S_01}});
    end
  endtask

  task automatic test_idle_valid_low();
    // Data toggling without valid must not change anything
    @(negedge clk);
    data = 8'h44;
    repeat (3) @(negedge clk);
    data = 8'h00;
    vectors++;
    if (key_count !== 8'h00 || seg !== {3{S_01}}) begin
      miscompares++;
      $display("FAIL valid_low: got %h/%h want 00/%h", key_count, seg, {3{S_01}});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    clear  = 1'b0;
    freeze = 1'b0;
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_overflow();
    test_clear();
    test_freeze();
    test_rst_mid();
    test_count_wrap();
    test_idle_valid_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
